// File: rtl/clk_div_ratio_ctrl.sv
// Ratio-change arbiter/sequencer for an integer clock divider: waits for a divided-clock
// falling edge, holds the divider in reset while loading the new ratio. Option: CLK_DIV_RATIO_CTRL_STATUS_EN.
module clk_div_ratio_ctrl #(
    parameter int N_REQ     = 2,
    parameter int RATIO_W   = 8,
    parameter int MAX_RATIO = 255,
    parameter int RST_RATIO = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*RATIO_W-1:0]   i_ratio,
    output logic [N_REQ-1:0]           o_ack,
    output logic [N_REQ-1:0]           o_err,
    input  logic                       i_div_clk,
    output logic [RATIO_W-1:0]         o_div_ratio,
    output logic                       o_div_rst_n,
    output logic                       o_busy
`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
    ,
    output logic [15:0]                o_chg_cnt,
    output logic                       o_timeout
`endif
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_LIM = 2 * MAX_RATIO + 4;
    localparam int TO_W   = $clog2(TO_LIM + 1);
    localparam int HC_W   = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_HOLD,
        S_RESP
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [RATIO_W-1:0]   gnt_ratio_q, gnt_ratio_d;
    logic                 resp_err_q, resp_err_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic                 drst_n_q, drst_n_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [HC_W-1:0]      hc_q, hc_d;
    logic                 sync1_q, sync2_q;
    logic [N_REQ-1:0]     ack_err_q;

    logic [N_REQ-1:0]     elig;
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic [RATIO_W-1:0]   win_ratio;
    logic                 fall;
    logic [N_REQ-1:0]     gnt_oh;
    int                   k;

    assign fall = sync2_q & ~sync1_q;

    // Round-robin: first eligible requester after the last one granted.
    always_comb begin
        elig      = i_req & ~ack_err_q;
        found     = 1'b0;
        win_idx   = '0;
        win_ratio = '0;
        k         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(rr_q) + 1 + i) % N_REQ;
            if (!found && elig[k]) begin
                found     = 1'b1;
                win_idx   = IDX_W'(k);
                win_ratio = i_ratio[k*RATIO_W +: RATIO_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_ratio_d = gnt_ratio_q;
        resp_err_d  = resp_err_q;
        ratio_d     = ratio_q;
        drst_n_d    = drst_n_q;
        to_cnt_d    = to_cnt_q;
        hc_d        = hc_q;
        unique case (state_q)
            S_INIT: begin
                drst_n_d = 1'b1;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                if (found) begin
                    gnt_idx_d   = win_idx;
                    gnt_ratio_d = win_ratio;
                    rr_d        = win_idx;
                    resp_err_d  = 1'b0;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (int'(gnt_ratio_q) < 2 || int'(gnt_ratio_q) > MAX_RATIO) begin
                    resp_err_d = 1'b1;
                    state_d    = S_RESP;
                end else if (gnt_ratio_q == ratio_q) begin
                    resp_err_d = 1'b0;
                    state_d    = S_RESP;
                end else begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // A stalled divider never shows an edge; give up after two max periods.
                if (fall || to_cnt_d == TO_W'(TO_LIM)) begin
                    drst_n_d = 1'b0;
                    ratio_d  = gnt_ratio_q;
                    hc_d     = '0;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                hc_d = hc_q + HC_W'(1);
                if (hc_q == HC_W'(HOLD_CYC - 1)) begin
                    drst_n_d = 1'b1;
                end
                if (hc_q == HC_W'(HOLD_CYC)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_INIT;
            rr_q        <= IDX_W'(N_REQ - 1);
            gnt_idx_q   <= '0;
            gnt_ratio_q <= '0;
            resp_err_q  <= 1'b0;
            ratio_q     <= RATIO_W'(RST_RATIO);
            drst_n_q    <= 1'b0;
            to_cnt_q    <= '0;
            hc_q        <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            ack_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_ratio_q <= gnt_ratio_d;
            resp_err_q  <= resp_err_d;
            ratio_q     <= ratio_d;
            drst_n_q    <= drst_n_d;
            to_cnt_q    <= to_cnt_d;
            hc_q        <= hc_d;
            sync1_q     <= i_div_clk;
            sync2_q     <= sync1_q;
            ack_err_q   <= o_ack | o_err;
        end
    end

    assign gnt_oh      = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;
    assign o_ack       = (state_q == S_RESP && !resp_err_q) ? gnt_oh : '0;
    assign o_err       = (state_q == S_RESP &&  resp_err_q) ? gnt_oh : '0;
    assign o_div_ratio = ratio_q;
    assign o_div_rst_n = drst_n_q;
    assign o_busy      = (state_q != S_IDLE);

`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
    logic        hold_entry;
    logic        to_exit;
    logic [15:0] chg_q;
    logic        tout_q;

    assign hold_entry = (state_q == S_WAIT) && (state_d == S_HOLD);
    assign to_exit    = hold_entry && !fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chg_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            if (hold_entry && chg_q != 16'hFFFF) begin
                chg_q <= chg_q + 16'd1;
            end
            if (to_exit) begin
                tout_q <= 1'b1;
            end
        end
    end

    assign o_chg_cnt = chg_q;
    assign o_timeout = tout_q;
`endif

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Scoreboard bench for clk_div_ratio_ctrl with a behavioural divider and
// a requester-level reference model (RR order, ratio legality, current ratio).
module tb_clk_div_ratio_ctrl;

    localparam int N_REQ     = 2;
    localparam int RATIO_W   = 9;
    localparam int MAX_RATIO = 255;
    localparam int RST_RATIO = 2;
    localparam int HOLD_CYC  = 2;
    localparam int TO_LAT    = 2 * MAX_RATIO + 4 + HOLD_CYC + 3;
    localparam int BUDGET    = 3000;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*RATIO_W-1:0] ratio;
    logic [N_REQ-1:0]         ack;
    logic [N_REQ-1:0]         err;
    logic                     div_clk;
    logic [RATIO_W-1:0]       div_ratio;
    logic                     div_rst_n;
    logic                     busy;
`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
    logic [15:0]              chg_cnt;
    logic                     tout;
`endif

    clk_div_ratio_ctrl #(
        .N_REQ(N_REQ), .RATIO_W(RATIO_W), .MAX_RATIO(MAX_RATIO),
        .RST_RATIO(RST_RATIO), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_ratio(ratio),
        .o_ack(ack), .o_err(err), .i_div_clk(div_clk),
        .o_div_ratio(div_ratio), .o_div_rst_n(div_rst_n), .o_busy(busy)
`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
        , .o_chg_cnt(chg_cnt), .o_timeout(tout)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural divider: period = ratio cycles, held low in reset.
    logic [RATIO_W-1:0] dcnt;
    logic               dclk;
    logic               stall = 1'b0;

    always @(posedge clk or negedge div_rst_n) begin
        if (!div_rst_n) begin
            dcnt <= '0;
            dclk <= 1'b0;
        end else begin
            if (dcnt >= div_ratio - 1) dcnt <= '0;
            else dcnt <= dcnt + 1'b1;
            dclk <= (dcnt >= (div_ratio >> 1));
        end
    end
    assign div_clk = dclk & ~stall;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        bit err;
        int ratio;
        int t0;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   vec = 0;
    int   bad = 0;
    int   cur_ratio;
    int   last_gnt;
    int   n_chg;

    function automatic void chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        cur_ratio = RST_RATIO;
        last_gnt  = N_REQ - 1;
        n_chg     = 0;
        sb.delete();
    endfunction

    // lat_mode: -1 no latency check, 0 check 2 cycles for err/no-change, >0 fixed value.
    function automatic void model_issue(input logic [N_REQ-1:0] mask, input int r[N_REQ],
                                        input int t0, input int lat_mode);
        logic [N_REQ-1:0] pend;
        bit               first;
        bit               same;
        exp_t             e;
        int               w;
        pend  = mask;
        first = 1'b1;
        while (pend != '0) begin
            w = -1;
            for (int i = 1; i <= N_REQ; i++) begin
                if (w < 0 && pend[(last_gnt + i) % N_REQ]) w = (last_gnt + i) % N_REQ;
            end
            e.idx = w;
            e.err = (r[w] < 2 || r[w] > MAX_RATIO);
            same  = !e.err && (r[w] == cur_ratio);
            if (!e.err && !same) begin
                cur_ratio = r[w];
                n_chg++;
            end
            e.ratio = cur_ratio;
            e.t0    = t0;
            e.lat   = 0;
            if (first && lat_mode > 0) e.lat = lat_mode;
            else if (first && lat_mode == 0 && (e.err || same)) e.lat = 2;
            sb.push_back(e);
            pend[w]  = 1'b0;
            last_gnt = w;
            first    = 1'b0;
        end
    endfunction

    // Monitor: pops the scoreboard on every response, watches divider handshake rules.
    initial begin
        int               low;
        bit               skip;
        logic [RATIO_W-1:0] prev;
        logic [N_REQ-1:0] v;
        int               gi;
        exp_t             e;
        low  = 0;
        skip = 1'b1;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                skip = 1'b1;
                low  = 0;
            end else begin
                v = ack | err;
                if (v != '0) begin
                    chk("resp_onehot", $countones(v), 1);
                    chk("ack_err_excl", int'(ack != '0 && err != '0), 0);
                    gi = 0;
                    for (int i = 0; i < N_REQ; i++) if (v[i]) gi = i;
                    if (sb.size() == 0) begin
                        vec++;
                        bad++;
                        $display("FAIL unexpected_resp: ack=%b err=%b", ack, err);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_idx", gi, e.idx);
                        chk("resp_is_err", int'(err != '0), int'(e.err));
                        chk("ratio_at_resp", int'(div_ratio), e.ratio);
                        if (e.lat > 0) chk("latency", cyc - e.t0, e.lat);
                    end
                end
                if (!div_rst_n) begin
                    low++;
                end else begin
                    if (low > 0 && !skip) chk("hold_len", low, HOLD_CYC);
                    low  = 0;
                    skip = 1'b0;
                end
                if (div_ratio != prev) chk("ratio_chg_rst_n", int'(div_rst_n), 0);
            end
            prev = div_ratio;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        if (n >= BUDGET) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_txn(input logic [N_REQ-1:0] mask, input int r[N_REQ], input int lat_mode);
        int               n;
        int               drop[N_REQ];
        logic [N_REQ-1:0] pend;
        wait_idle();
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            ratio[i*RATIO_W +: RATIO_W] = RATIO_W'(r[i]);
            drop[i] = -1;
        end
        model_issue(mask, r, cyc, lat_mode);
        req  = mask;
        pend = mask;
        n    = 0;
        while (req != '0 && n < BUDGET) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N_REQ; i++) begin
                if (pend[i] && (ack[i] || err[i])) begin
                    pend[i] = 1'b0;
                    drop[i] = ($urandom_range(0, 1) == 1) ? 2 : 0;
                end
                if (drop[i] == 0) begin
                    req[i]  = 1'b0;
                    drop[i] = -1;
                end else if (drop[i] > 0) begin
                    drop[i]--;
                end
            end
        end
        if (n >= BUDGET) begin
            chk("txn_timeout", int'(req), 0);
            req = '0;
            sb.delete();
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ratio", int'(div_ratio), RST_RATIO);
        chk("rst_div_rst_n", int'(div_rst_n), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ack", int'(ack | err), 0);
        rst_n = 1'b1;
        #1;
        chk("init_busy", int'(busy), 1);
        chk("init_div_rst_n", int'(div_rst_n), 0);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_div_rst_n", int'(div_rst_n), 1);
        chk("idle_ratio", int'(div_ratio), RST_RATIO);
    endtask

    function automatic int pick_ratio();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return $urandom_range(0, 1);
        if (sel == 1) return $urandom_range(MAX_RATIO + 1, (1 << RATIO_W) - 1);
        if (sel == 2) return cur_ratio;
        if (sel == 3) return $urandom_range(2, MAX_RATIO);
        return $urandom_range(2, 20);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r[N_REQ];
        int n;
        rst_n = 1'b0;
        req   = '0;
        ratio = '0;
        apply_reset();

        r = '{5, 9};
        run_txn(2'b01, r, 0);
        r = '{5, 1};
        run_txn(2'b10, r, 0);
        r = '{5, MAX_RATIO + 1};
        run_txn(2'b10, r, 0);
        r = '{5, 4};
        run_txn(2'b01, r, 0);

        apply_reset();
        r = '{3, 4};
        run_txn(2'b11, r, 0);
        r = '{6, 8};
        run_txn(2'b11, r, 0);

        for (int t = 0; t < 30; t++) begin
            logic [N_REQ-1:0] m;
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) r[i] = pick_ratio();
            run_txn(m, r, 0);
        end

        stall = 1'b1;
        repeat (6) @(negedge clk);
        r = '{(cur_ratio == 7) ? 9 : 7, 3};
`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
        chk("timeout_before", int'(tout), 0);
`endif
        run_txn(2'b01, r, TO_LAT);
        stall = 1'b0;
`ifdef CLK_DIV_RATIO_CTRL_STATUS_EN
        chk("timeout_sticky", int'(tout), 1);
        chk("chg_cnt", int'(chg_cnt), n_chg);
`endif

        wait_idle();
        @(negedge clk);
        ratio[0 +: RATIO_W] = RATIO_W'((cur_ratio == 11) ? 12 : 11);
        req = 2'b01;
        n = 0;
        while (div_rst_n && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", int'(div_rst_n), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ratio", int'(div_ratio), RST_RATIO);
        chk("async_div_rst_n", int'(div_rst_n), 0);
        chk("async_ack", int'(ack), 0);
        chk("async_busy", int'(busy), 1);
        req = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_ratio", int'(div_ratio), RST_RATIO);
        r = '{2, 6};
        run_txn(2'b11, r, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
